// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache: address field
// layout, line geometry and controller state encodings.
package cache_pkg;

    localparam int unsigned LINE_BITS      = 128;
    localparam int unsigned WORDS_PER_LINE = 4;

    localparam int unsigned OFFSET_W   = 2;
    localparam int unsigned INDEX_W    = 5;
    localparam int unsigned TAG_W      = 3;
    localparam int unsigned OFFSET_LSB = 0;
    localparam int unsigned INDEX_LSB  = 2;
    localparam int unsigned TAG_LSB    = 7;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t FILL  = 2'd1;
    localparam state_t WRITE = 2'd2;

endpackage

// File: rtl/cache_if.sv
// CPU-side request/response and memory-side fill/write signals of the cache.
// master drives requests and memory responses; slave is the controller.
interface cache_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_SIZE = 10
);

    logic                           cpu_read;
    logic                           cpu_write;
    logic [ADDR_SIZE-1:0]           cpu_addr;
    logic [WIDTH-1:0]               cpu_wdata;
    logic [WIDTH-1:0]               cpu_rdata;
    logic                           cpu_stall;
    logic                           mem_read_en;
    logic                           mem_write_en;
    logic [ADDR_SIZE-1:0]           mem_addr;
    logic [WIDTH-1:0]               mem_wdata;
    logic                           mem_ready;
    logic [cache_pkg::LINE_BITS-1:0] mem_line;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready, mem_line,
        input  cpu_rdata, cpu_stall, mem_read_en, mem_write_en, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready, mem_line,
        output cpu_rdata, cpu_stall, mem_read_en, mem_write_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_data_array.sv
// Cache storage: per-line valid bit, tag and 128-bit data with one
// asynchronous read port and one write port (whole line or single word).
module cache_data_array
    import cache_pkg::*;
#(
    parameter int unsigned LINES = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic                 line_we,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic                 word_we,
    input  logic [OFFSET_W-1:0]  wr_offset,
    input  logic [WIDTH-1:0]     wr_word
);

    logic [LINES-1:0]     valid;
    logic [TAG_W-1:0]     tags  [LINES];
    logic [LINE_BITS-1:0] lines [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = lines[rd_index];

    // Only valid bits are reset; tag/data contents are don't-care until filled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (line_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end else if (word_we) begin
            for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
                if (wr_offset == k[OFFSET_W-1:0]) begin
                    lines[wr_index][k*WIDTH +: WIDTH] <= wr_word;
                end
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// zero-latency read hits, whole-line fills and single-word memory writes.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned LINES     = 32
) (
    input  logic   clk,
    input  logic   rst,
    cache_if.slave bus
);

    state_t state, state_nx;

    logic [TAG_W-1:0]     req_tag;
    logic [INDEX_W-1:0]   req_index;
    logic [OFFSET_W-1:0]  req_offset;
    logic [TAG_W-1:0]     fill_tag;
    logic [INDEX_W-1:0]   fill_index;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic [WIDTH-1:0]     rd_word;
    logic                 hit;
    logic                 line_we;
    logic                 word_we;

    logic                 stall;
    logic [WIDTH-1:0]     rdata;
    logic                 read_en;
    logic                 write_en;
    logic [ADDR_SIZE-1:0] maddr;
    logic [WIDTH-1:0]     mwdata;

    assign req_tag    = bus.cpu_addr[TAG_LSB    +: TAG_W];
    assign req_index  = bus.cpu_addr[INDEX_LSB  +: INDEX_W];
    assign req_offset = bus.cpu_addr[OFFSET_LSB +: OFFSET_W];

    assign hit = rd_valid && (rd_tag == req_tag);

    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
            if (req_offset == k[OFFSET_W-1:0]) begin
                rd_word = rd_line[k*WIDTH +: WIDTH];
            end
        end
    end

    cache_data_array #(
        .LINES (LINES),
        .WIDTH (WIDTH)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (req_index),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_index  ((state == FILL) ? fill_index : req_index),
        .line_we   (line_we),
        .wr_tag    (fill_tag),
        .wr_line   (bus.mem_line),
        .word_we   (word_we),
        .wr_offset (req_offset),
        .wr_word   (bus.cpu_wdata)
    );

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        rdata    = '0;
        line_we  = 1'b0;
        word_we  = 1'b0;
        read_en  = 1'b0;
        write_en = 1'b0;
        maddr    = '0;
        mwdata   = '0;
        case (state)
            IDLE: begin
                if (bus.cpu_write) begin
                    stall    = 1'b1;
                    state_nx = WRITE;
                end else if (bus.cpu_read) begin
                    if (hit) begin
                        rdata = rd_word;
                    end else begin
                        stall    = 1'b1;
                        state_nx = FILL;
                    end
                end
            end
            FILL: begin
                // Fill address is latched so the fill completes even if the
                // CPU withdraws or changes its request mid-transaction.
                read_en = 1'b1;
                maddr   = ADDR_SIZE'({fill_tag, fill_index, {OFFSET_W{1'b0}}});
                stall   = 1'b1;
                if (bus.mem_ready) begin
                    line_we  = 1'b1;
                    state_nx = IDLE;
                end
            end
            WRITE: begin
                write_en = 1'b1;
                maddr    = bus.cpu_addr;
                mwdata   = bus.cpu_wdata;
                stall    = !bus.mem_ready;
                if (bus.mem_ready) begin
                    word_we  = hit;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fill_tag   <= '0;
            fill_index <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == FILL) begin
                fill_tag   <= req_tag;
                fill_index <= req_index;
            end
        end
    end

    assign bus.cpu_stall    = stall;
    assign bus.cpu_rdata    = rdata;
    assign bus.mem_read_en  = read_en;
    assign bus.mem_write_en = write_en;
    assign bus.mem_addr     = maddr;
    assign bus.mem_wdata    = mwdata;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a word-addressed memory model answers
// fills and writes after a fixed latency; results are compared to constants.
module tb_cache_controller;

    logic clk;
    logic rst;

    cache_if #(.WIDTH(32), .ADDR_SIZE(10)) bus ();

    cache_controller #(
        .WIDTH     (32),
        .ADDR_SIZE (10),
        .LINES     (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent access
    logic [31:0] r_rdata, r_first_rdata, r_fill_addr, r_wr_addr, r_wr_data;
    int          r_cycles, r_fill_cyc, r_wr_cyc;
    logic        r_both, r_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Entered and left at a negedge. Memory answers on the third cycle of a
    // mem_read_en/mem_write_en burst.
    task automatic access(input logic rd, input logic wr, input logic [9:0] addr,
                          input logic [31:0] wdata);
        int ctr;
        logic [9:0] a;
        ctr = 0;
        r_cycles = 0; r_fill_cyc = 0; r_wr_cyc = 0; r_both = 1'b0; r_done = 1'b0;
        r_rdata = '0; r_first_rdata = '0; r_fill_addr = '0; r_wr_addr = '0; r_wr_data = '0;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        while (!r_done && r_cycles < 40) begin
            bus.mem_ready = (bus.mem_read_en || bus.mem_write_en) && ctr >= 2;
            if (bus.mem_ready && bus.mem_read_en) begin
                a = {bus.mem_addr[9:2], 2'b00};
                bus.mem_line = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
            end
            if (bus.mem_ready && bus.mem_write_en)
                mem[bus.mem_addr] = bus.mem_wdata;
            #1;
            if (r_cycles == 0) r_first_rdata = bus.cpu_rdata;
            if (bus.mem_read_en && bus.mem_write_en) r_both = 1'b1;
            if (bus.mem_read_en) begin
                if (r_fill_cyc == 0) r_fill_addr = 32'(bus.mem_addr);
                r_fill_cyc++;
            end
            if (bus.mem_write_en) begin
                if (r_wr_cyc == 0) begin
                    r_wr_addr = 32'(bus.mem_addr);
                    r_wr_data = bus.mem_wdata;
                end
                r_wr_cyc++;
            end
            r_cycles++;
            if (!bus.cpu_stall) begin
                r_rdata = bus.cpu_rdata;
                r_done  = 1'b1;
            end else begin
                if (bus.mem_read_en || bus.mem_write_en) ctr++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hD000_0000 | 32'(i);
        rst = 1'b0;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.mem_ready = 1'b0; bus.mem_line = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall",    32'(bus.cpu_stall),    32'd0);
        check("rst_rd_en",    32'(bus.mem_read_en),  32'd0);
        check("rst_wr_en",    32'(bus.mem_write_en), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr),     32'd0);
        check("rst_wdata",    bus.mem_wdata,         32'd0);
        check("rst_rdata",    bus.cpu_rdata,         32'd0);
        @(negedge clk);
        rst = 1'b1;

        // cold miss on 0x004
        access(1'b1, 1'b0, 10'h004, '0);
        check("m004_done",  32'(r_done),            32'd1);
        check("m004_fill",  32'(r_fill_cyc > 0),    32'd1);
        check("m004_addr",  r_fill_addr,            32'h004);
        check("m004_rd0",   r_first_rdata,          32'd0);
        check("m004_data",  r_rdata,                32'hD000_0004);

        // hit on same line, zero latency
        access(1'b1, 1'b0, 10'h006, '0);
        check("h006_fill",  32'(r_fill_cyc),        32'd0);
        check("h006_lat",   32'(r_cycles),          32'd1);
        check("h006_data",  r_rdata,                32'hD000_0006);

        // store hit, write-through
        access(1'b0, 1'b1, 10'h005, 32'h1234);
        check("w005_done",  32'(r_done),            32'd1);
        check("w005_wr",    32'(r_wr_cyc > 0),      32'd1);
        check("w005_addr",  r_wr_addr,              32'h005);
        check("w005_wdata", r_wr_data,              32'h1234);
        check("w005_fill",  32'(r_fill_cyc),        32'd0);
        check("w005_both",  32'(r_both),            32'd0);
        access(1'b1, 1'b0, 10'h005, '0);
        check("h005_fill",  32'(r_fill_cyc),        32'd0);
        check("h005_data",  r_rdata,                32'h0000_1234);

        // conflict eviction: same index, tag 1
        access(1'b1, 1'b0, 10'h084, '0);
        check("m084_fill",  32'(r_fill_cyc > 0),    32'd1);
        check("m084_addr",  r_fill_addr,            32'h084);
        check("m084_data",  r_rdata,                32'hD000_0084);
        access(1'b1, 1'b0, 10'h004, '0);
        check("r004_fill",  32'(r_fill_cyc > 0),    32'd1);
        check("r004_data",  r_rdata,                32'hD000_0004);

        // read+write together behaves as a write only
        access(1'b1, 1'b1, 10'h010, 32'h0000_BEEF);
        check("rw010_wr",   32'(r_wr_cyc > 0),      32'd1);
        check("rw010_fill", 32'(r_fill_cyc),        32'd0);
        check("rw010_both", 32'(r_both),            32'd0);
        check("rw010_addr", r_wr_addr,              32'h010);
        check("rw010_rd",   r_rdata,                32'd0);
        access(1'b1, 1'b0, 10'h010, '0);
        check("r010_fill",  32'(r_fill_cyc > 0),    32'd1);
        check("r010_data",  r_rdata,                32'h0000_BEEF);

        // store miss does not allocate
        access(1'b0, 1'b1, 10'h085, 32'h55);
        check("w085_addr",  r_wr_addr,              32'h085);
        access(1'b1, 1'b0, 10'h005, '0);
        check("h005b_fill", 32'(r_fill_cyc),        32'd0);
        check("h005b_data", r_rdata,                32'h0000_1234);
        access(1'b1, 1'b0, 10'h085, '0);
        check("m085_fill",  32'(r_fill_cyc > 0),    32'd1);
        check("m085_data",  r_rdata,                32'h0000_0055);

        // stray mem_ready while idle must not touch the cache
        bus.mem_line  = '1;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.mem_ready = 1'b0;
        access(1'b1, 1'b0, 10'h084, '0);
        check("h084_fill",  32'(r_fill_cyc),        32'd0);
        check("h084_data",  r_rdata,                32'hD000_0084);

        // reset in the middle of a fill
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 10'h100;
        repeat (2) @(negedge clk);
        #1;
        check("rf_rd_en",   32'(bus.mem_read_en),   32'd1);
        check("rf_addr",    32'(bus.mem_addr),      32'h100);
        bus.mem_line  = '1;
        bus.mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("rf_rst_rd_en", 32'(bus.mem_read_en), 32'd0);
        check("rf_rst_addr",  32'(bus.mem_addr),    32'd0);
        bus.cpu_read  = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("rf_rst_stall", 32'(bus.cpu_stall),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 10'h100, '0);
        check("m100_fill",  32'(r_fill_cyc > 0),    32'd1);
        check("m100_data",  r_rdata,                32'hD000_0100);
        access(1'b1, 1'b0, 10'h006, '0);
        check("m006_fill",  32'(r_fill_cyc > 0),    32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, word-address width.
REQ-003 SHALL have parameter LINES, default 32, cache line count; line = 4 words (128 bits).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cpu_read  input  1  CPU load request, held until cpu_stall low.
REQ-007 SHALL have port cpu_write  input  1  CPU store request, held until cpu_stall low.
REQ-008 SHALL have port cpu_addr  input  ADDR_SIZE  word address: tag[9:7], index[6:2], offset[1:0].
REQ-009 SHALL have port cpu_wdata  input  WIDTH  store data.
REQ-010 SHALL have port cpu_rdata  output  WIDTH  load data, valid when cpu_read=1 and cpu_stall=0.
REQ-011 SHALL have port cpu_stall  output  1  request not yet complete.
REQ-012 SHALL have port mem_read_en  output  1  line-fill request to main memory.
REQ-013 SHALL have port mem_write_en  output  1  single-word write to main memory.
REQ-014 SHALL have port mem_addr  output  ADDR_SIZE  memory word address.
REQ-015 SHALL have port mem_wdata  output  WIDTH  memory write data.
REQ-016 SHALL have port mem_ready  input  1  memory completed current fill or write.
REQ-017 SHALL have port mem_line  input  128  fill data; word k in bits [32k+31:32k].

Function
REQ-018 SHALL be direct-mapped; per line: valid bit, 3-bit tag, 128-bit data.
REQ-019 SHALL implement FSM states IDLE, FILL, WRITE.
REQ-020 Hit SHALL mean valid[index]=1 and tag[index]=cpu_addr tag.
REQ-021 IDLE, cpu_read hit: cpu_rdata = stored word[offset] combinationally, cpu_stall=0, no memory traffic (zero-cycle latency).
REQ-022 IDLE, cpu_read miss: cpu_stall=1 same cycle; next state FILL.
REQ-023 FILL: mem_read_en=1, mem_addr={tag,index,2'b00}, held until mem_ready sampled 1.
REQ-024 On mem_ready in FILL: line data <= mem_line, tag updated, valid set, mem_read_en dropped next cycle, state -> IDLE; retried read hits one cycle later.
REQ-025 Stores SHALL be write-through, no-write-allocate: IDLE, cpu_write -> cpu_stall=1, state WRITE.
REQ-026 WRITE: mem_write_en=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata until mem_ready=1; then -> IDLE, cpu_stall=0 that cycle.
REQ-027 On store hit, cached word[offset] SHALL update at WRITE completion; store miss leaves cache unchanged.
REQ-028 cpu_read and cpu_write both 1: treated as write only.
REQ-029 mem_read_en and mem_write_en SHALL never both be 1.
REQ-030 mem_ready in IDLE SHALL be ignored.
REQ-031 Request dropped mid-FILL: fill still completes, then IDLE.
REQ-032 cpu_rdata SHALL be 0 whenever not a read hit in IDLE.

Reset
REQ-033 rst=0 SHALL asynchronously force state IDLE, all valid bits 0, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0.
REQ-034 cpu_stall SHALL read 0 in reset with no request; data/tag arrays need not reset.
REQ-035 Reset mid-FILL or mid-WRITE SHALL abort the transaction; no partial line becomes valid.

Structure
REQ-036 Shared package cache_pkg SHALL hold state enum, LINE_BITS=128, TAG/INDEX/OFFSET widths and bit positions.
REQ-037 Storage SHALL be sub-module cache_data_array (valid/tag/data, one read port, one line-write or word-write port); FSM in cache_controller.

Verification
REQ-038 After reset, read 0x004 with memory words 0x004..0x007=A,B,C,D -> miss, mem_read_en until mem_ready, mem_addr=0x004, later read returns A with stall 0.
REQ-039 Then read 0x006 -> hit, cpu_rdata=C same cycle, no mem_read_en.
REQ-040 Write 0x005=0x1234 (hit) -> one WRITE, mem_addr=0x005, mem_wdata=0x1234; read 0x005 -> 0x1234 no fill.
REQ-041 Read 0x084 (same index, tag 1) -> miss, refill evicts; read 0x004 -> miss again.
REQ-042 cpu_read=cpu_write=1 at 0x010 -> only mem_write_en asserted, cache unchanged.
REQ-043 rst low during FILL -> outputs zeroed immediately; read same address after reset -> miss.
